// File: rtl/apb_regbus_bridge.sv
// APB slave front-end for the register file: turns APB transfers into one-hot
// read/write strobes and muxes the register outputs back onto prdata.
module apb_regbus_bridge #(
  parameter int                  NB_REGS   = 12,
  parameter int                  DATA_W    = 16,
  parameter int                  ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = '0,
  parameter logic [NB_REGS-1:0]  RO_MASK   = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_W-1:0]         paddr,
  input  logic [DATA_W-1:0]         pwdata,
  output logic [DATA_W-1:0]         prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic [NB_REGS-1:0]        read,
  output logic [NB_REGS-1:0]        write,
  output logic [DATA_W-1:0]         wdata,
  input  logic [NB_REGS*DATA_W-1:0] q_bus
);

  typedef enum logic [2:0] {IDLE, ACC_W, ACC_R1, ACC_R2, ACC_ERR} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   prdata_q, wdata_q, rd_mux_d;
  logic                pready_q, pslverr_q;
  logic [NB_REGS-1:0]  read_q, write_q, dec_oh_d;
  logic [ADDR_W-1:0]   off_d;
  logic [ADDR_W-2:0]   idx_d;
  logic                ro_hit_d, valid_d;

  assign off_d = paddr - BASE_ADDR;
  assign idx_d = off_d[ADDR_W-1:1];

  // One-hot decode; an index past the last register leaves dec_oh_d empty.
  always_comb begin
    dec_oh_d = '0;
    ro_hit_d = 1'b0;
    for (int i = 0; i < NB_REGS; i++) begin
      if (idx_d == (ADDR_W-1)'(i)) begin
        dec_oh_d[i] = 1'b1;
        ro_hit_d    = RO_MASK[i];
      end
    end
  end

  assign valid_d = !off_d[0] && (|dec_oh_d);

  // The read strobe is still held in ACC_R1, so it doubles as the mux select.
  always_comb begin
    rd_mux_d = '0;
    for (int i = 0; i < NB_REGS; i++)
      if (read_q[i]) rd_mux_d = rd_mux_d | q_bus[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      read_q    <= '0;
      write_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= IDLE;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      read_q    <= '0;
      write_q   <= '0;
      case (state_q)
        IDLE: begin
          if (psel && !penable) begin
            if (!valid_d || (pwrite && ro_hit_d)) begin
              state_q   <= ACC_ERR;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
            end else if (pwrite) begin
              state_q  <= ACC_W;
              write_q  <= dec_oh_d;
              wdata_q  <= pwdata;
              pready_q <= 1'b1;
            end else begin
              state_q <= ACC_R1;
              read_q  <= dec_oh_d;
            end
          end
        end
        ACC_R1: begin
          if (psel) begin
            state_q  <= ACC_R2;
            prdata_q <= rd_mux_d;
            pready_q <= 1'b1;
          end
        end
        // ACC_W, ACC_R2 and ACC_ERR complete (or abort) back to IDLE.
        default: ;
      endcase
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign read    = read_q;
  assign write   = write_q;
  assign wdata   = wdata_q;

endmodule

// File: tb/tb_apb_regbus_bridge.sv
// Bench for apb_regbus_bridge: table of APB transfers with a scoreboard queue,
// plus hand sequences for reset, abort, back-to-back and stray-penable cases.
module tb_apb_regbus_bridge;
  localparam int NB = 12;
  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata, wdata;
  logic          pready, pslverr;
  logic [NB-1:0] read, write;
  logic [NB*DW-1:0] q_bus;
  logic [DW-1:0] regs [NB];

  always #5 clk = ~clk;

  apb_regbus_bridge #(.NB_REGS(NB), .DATA_W(DW), .ADDR_W(AW),
                      .BASE_ADDR(8'h00), .RO_MASK(12'h006)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .read(read), .write(write), .wdata(wdata), .q_bus(q_bus)
  );

  // Register file stub: reset values i*0x0101, except slot 2 = 0x1234.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) regs[i] <= (i == 2) ? 16'h1234 : 16'(i * 257);
    end else begin
      for (int i = 0; i < NB; i++) if (write[i]) regs[i] <= wdata;
    end
  end

  always_comb begin
    q_bus = '0;
    for (int i = 0; i < NB; i++) q_bus[i*DW +: DW] = regs[i];
  end

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [NB-1:0] strb;
    logic          err;
    logic [DW-1:0] rd;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t sbq[$];
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input logic [NB-1:0] s, input logic e, input logic [DW-1:0] rd);
    vec_t v;
    v.wr = wr; v.addr = a; v.wd = wd; v.strb = s; v.err = e; v.rd = rd;
    return v;
  endfunction

  // One full transfer; leaves psel/penable high so a following call is back-to-back.
  task automatic xfer(input vec_t v, input string tag);
    int            waits;
    vec_t          e;
    logic [NB-1:0] exp_rd, exp_wr;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr; pwdata = v.wd;
    sbq.push_back(v);
    @(posedge clk); #1;
    penable = 1'b1; paddr = ~v.addr; pwdata = ~v.wd;
    @(negedge clk);
    exp_rd = v.wr ? '0 : v.strb;
    exp_wr = v.wr ? v.strb : '0;
    chk({tag, " strobe"}, 32'({read, write}), 32'({exp_rd, exp_wr}));
    if (v.wr && !v.err) chk({tag, " wdata"}, 32'(wdata), 32'(v.wd));
    waits = 0;
    while (!pready && waits < 4) begin
      @(negedge clk);
      waits++;
      chk({tag, " strobe_off"}, 32'({read, write}), 32'h0);
    end
    chk({tag, " pready"}, 32'(pready), 32'h1);
    e = sbq.pop_front();
    chk({tag, " waits"}, 32'(waits), (e.wr || e.err) ? 32'h0 : 32'h1);
    chk({tag, " pslverr"}, 32'(pslverr), 32'(e.err));
    chk({tag, " prdata"}, 32'(prdata), 32'(e.rd));
  endtask

  task automatic idle(input string tag);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk({tag, " idle"}, 32'({pready, pslverr, prdata, read, write}), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(1, 8'h06, 16'hA5A5, 12'h008, 0, 16'h0000);
    tbl[1]  = mk(0, 8'h04, 16'h0000, 12'h004, 0, 16'h1234);
    tbl[2]  = mk(0, 8'h06, 16'h0000, 12'h008, 0, 16'hA5A5);
    tbl[3]  = mk(0, 8'h18, 16'h0000, 12'h000, 1, 16'h0000);
    tbl[4]  = mk(1, 8'h03, 16'h5555, 12'h000, 1, 16'h0000);
    tbl[5]  = mk(1, 8'h02, 16'hDEAD, 12'h000, 1, 16'h0000);
    tbl[6]  = mk(0, 8'h02, 16'h0000, 12'h002, 0, 16'h0101);
    tbl[7]  = mk(1, 8'h16, 16'h7777, 12'h800, 0, 16'h0000);
    tbl[8]  = mk(0, 8'h16, 16'h0000, 12'h800, 0, 16'h7777);
    tbl[9]  = mk(0, 8'h03, 16'h0000, 12'h000, 1, 16'h0000);
    tbl[10] = mk(1, 8'h04, 16'h9999, 12'h000, 1, 16'h0000);
    tbl[11] = mk(1, 8'hFE, 16'h4444, 12'h000, 1, 16'h0000);

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    #12;
    chk("reset outs", 32'({pready, pslverr, prdata, read, write}), 32'h0);
    chk("reset wdata", 32'(wdata), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // penable without a setup phase must not start a transfer
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 16'hFFFF;
    repeat (2) begin
      @(negedge clk);
      chk("stray penable", 32'({pready, pslverr, write}), 32'h0);
    end
    idle("stray");

    for (int i = 0; i < 12; i++) begin
      xfer(tbl[i], $sformatf("vec%0d", i));
      idle($sformatf("vec%0d", i));
    end

    // asynchronous reset while in ACC_R1
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h04;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    chk("rst pre read", 32'(read), 32'h004);
    #2 rst = 1'b1;
    #1 chk("rst async", 32'({pready, prdata, read}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    xfer(mk(1, 8'h00, 16'h00FF, 12'h001, 0, 16'h0000), "post rst wr");
    idle("post rst wr");
    xfer(mk(0, 8'h00, 16'h0000, 12'h001, 0, 16'h00FF), "post rst rd");
    idle("post rst rd");

    // back-to-back write then read of idx 5
    xfer(mk(1, 8'h0A, 16'hBEEF, 12'h020, 0, 16'h0000), "b2b wr");
    xfer(mk(0, 8'h0A, 16'h0000, 12'h020, 0, 16'hBEEF), "b2b rd");
    idle("b2b");

    // psel dropped during ACC_R1
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h0A;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    chk("abort read", 32'({pready, read}), 32'h020);
    psel = 1'b0; penable = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abort quiet", 32'({pready, pslverr, prdata, read, write}), 32'h0);
    end
    xfer(mk(0, 8'h0A, 16'h0000, 12'h020, 0, 16'hBEEF), "after abort");
    idle("after abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_regbus_bridge.md
Name: apb_regbus_bridge

Overview:
- APB slave front-end, directly upstream of the register-file block.
- Converts APB transfers into the one-hot per-register read/write strobes and the write-data bus that the register file consumes.
- Muxes the register file's per-register q outputs back onto prdata.
- Generates pready wait states and pslverr for illegal accesses.

Parameters:
NB_REGS, 12, number of registers (strobe width)
DATA_W, 16, register and APB data width
ADDR_W, 8, APB byte-address width
BASE_ADDR, 0, byte address of register 0
RO_MASK, 0, bit i set = register i read-only; APB write to it is an error

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  reset, asynchronous, active-high
psel  input  1  APB select
penable  input  1  APB enable (access phase)
pwrite  input  1  1=write, 0=read
paddr  input  ADDR_W  APB byte address
pwdata  input  DATA_W  APB write data
prdata  output  DATA_W  APB read data
pready  output  1  APB ready
pslverr  output  1  APB error, valid only with pready
read  output  NB_REGS  one-hot read strobe to register file
write  output  NB_REGS  one-hot write strobe to register file
wdata  output  DATA_W  write data to register file
q_bus  input  NB_REGS*DATA_W  flattened register outputs; register i at bits [i*DATA_W +: DATA_W]

Behaviour:
- All outputs are registered.
- Reset (asynchronous): state=IDLE; prdata=0, pready=0, pslverr=0, read=0, write=0, wdata=0.
- Decode:
  - off = paddr - BASE_ADDR, modulo 2^ADDR_W.
  - idx = off >> 1.
  - Invalid if off[0]=1 (misaligned) or idx >= NB_REGS.
  - Write-error if valid, pwrite=1 and RO_MASK[idx]=1.
- FSM states: IDLE, ACC_W, ACC_R1, ACC_R2, ACC_ERR.
- IDLE:
  - Waits for setup phase (psel=1, penable=0); latches idx, pwrite, pwdata at that edge.
  - penable=1 without a preceding setup is ignored.
  - Valid write -> ACC_W: write[idx]=1, wdata=pwdata, pready=1.
  - Valid read -> ACC_R1: read[idx]=1, pready=0.
  - Invalid or write-error -> ACC_ERR: pready=1, pslverr=1, no strobe, prdata=0.
- ACC_W (first access cycle):
  - Transfer completes here (zero wait states).
  - Next edge: write=0, pready=0, -> IDLE.
- ACC_R1 (one wait state):
  - read strobe high for exactly this cycle.
  - Next edge: prdata=q_bus[idx], pready=1, read=0, -> ACC_R2.
- ACC_R2: read completes. Next edge: prdata=0, pready=0, -> IDLE.
- ACC_ERR: completes. Next edge: pready=0, pslverr=0, -> IDLE.
- Strobes are never high for more than one cycle, and never more than one bit at a time.
- prdata is 0 whenever pready=0 or pslverr=1.
- Back-to-back: a setup phase in the cycle following completion is accepted; there are no idle cycles between transfers.
- Abort: psel=0 in any ACC_* state -> next edge clears all outputs, -> IDLE. No prdata capture occurs if the abort happens in ACC_R1.
- Reset mid-transfer: outputs clear immediately (asynchronous); the transfer is lost. The first setup after reset release is served normally.
- If pwdata or paddr change during the access phase, the values latched at setup are used.

Test Plan:
1. Write at paddr 0x06, pwdata 0xA5A5 -> write=12'h008 for exactly 1 cycle, wdata=0xA5A5, pready=1 and pslverr=0 in the same (first access) cycle.
2. Read paddr 0x04 with q_bus slot 2 = 0x1234 -> read=12'h004 in first access cycle with pready=0; second access cycle pready=1, prdata=0x1234; prdata returns to 0 next cycle.
3. Illegal accesses:
   - paddr 0x18 (idx 12) -> no strobe, pready=1 and pslverr=1 in first access cycle, prdata=0.
   - paddr 0x03 (misaligned) -> same response.
4. RO_MASK=12'h006:
   - Write paddr 0x02 -> pslverr=1, write stays 0.
   - Read paddr 0x02 -> normal 1-wait read, pslverr=0.
5. rst asserted mid-read (ACC_R1) -> read, pready, prdata go to 0 without waiting for clk. After release, write 0x00FF at paddr 0x00 -> write=12'h001, completes normally.
6. Back-to-back with the register file connected:
   - Write 0xBEEF to idx 5, then immediately read idx 5 (setup on the cycle after write completion) -> prdata=0xBEEF.
   - Separately, psel dropped during ACC_R1 -> no pready, state returns to IDLE.
